// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART-TX handshake bundle for uart_tx_arbiter.
// master = arbiter side, slave = requesters plus UART transmitter side.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   i_Req_Valid;
  logic [NUM_REQ-1:0]   i_Req_Lock;
  logic [8*NUM_REQ-1:0] i_Req_Byte;
  logic [NUM_REQ-1:0]   o_Req_Ack;
  logic [NUM_REQ-1:0]   o_Req_Done;
  logic [ID_W-1:0]      o_Grant_ID;
  logic                 o_Active;
  logic                 o_Error;
  logic                 o_TX_Valid;
  logic [7:0]           o_TX_Byte;
  logic                 i_TX_Busy;
  logic                 i_TX_Done;

  modport master (
    input  i_Req_Valid, i_Req_Lock, i_Req_Byte, i_TX_Busy, i_TX_Done,
    output o_Req_Ack, o_Req_Done, o_Grant_ID, o_Active, o_Error, o_TX_Valid, o_TX_Byte
  );

  modport slave (
    output i_Req_Valid, i_Req_Lock, i_Req_Byte, i_TX_Busy, i_TX_Done,
    input  o_Req_Ack, o_Req_Done, o_Grant_ID, o_Active, o_Error, o_TX_Valid, o_TX_Byte
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources,
// with message lock, valid/busy/done sequencing and a busy-start watchdog.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic               i_System_Clock,
  input  logic               i_Rst_L,
  uart_tx_arbiter_if.master  bus
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);
  localparam int unsigned WD_W = $clog2(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_q, rr_d;
  logic               lock_vld_q, lock_vld_d;
  logic [ID_W-1:0]    lock_id_q, lock_id_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [ID_W-1:0]    gid_q, gid_d;
  logic [7:0]         byte_q, byte_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               active_q, active_d;
  logic               error_q, error_d;
  logic               tx_valid_q, tx_valid_d;

  logic               win_vld;
  logic [ID_W-1:0]    win_id;
  logic [7:0]         win_byte;
  logic               complete;

  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= int'(NUM_REQ)) s = s - int'(NUM_REQ);
    return ID_W'(s);
  endfunction

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + ID_W'(1);
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
    logic [NUM_REQ-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

  // Arbitration: lock owner only, else first valid from the RR pointer (descending
  // scan so the nearest offset wins).
  always_comb begin
    win_vld  = 1'b0;
    win_id   = '0;
    win_byte = '0;
    if (lock_vld_q) begin
      win_vld = bus.i_Req_Valid[lock_id_q];
      win_id  = lock_id_q;
    end else begin
      for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
        if (bus.i_Req_Valid[rr_idx(rr_q, i)]) begin
          win_vld = 1'b1;
          win_id  = rr_idx(rr_q, i);
        end
      end
    end
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (ID_W'(k) == win_id) win_byte = bus.i_Req_Byte[8*k +: 8];
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    lock_vld_d = lock_vld_q;
    lock_id_d  = lock_id_q;
    wd_d       = wd_q;
    gid_d      = gid_q;
    byte_d     = byte_q;
    ack_d      = '0;
    done_d     = '0;
    active_d   = active_q;
    error_d    = 1'b0;
    tx_valid_d = 1'b0;
    complete   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (win_vld && !bus.i_TX_Busy) begin
          byte_d     = win_byte;
          gid_d      = win_id;
          ack_d      = onehot(win_id);
          tx_valid_d = 1'b1;
          active_d   = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (bus.i_TX_Done) begin
          complete = 1'b1;
        end else if (bus.i_TX_Busy) begin
          state_d = S_WAIT_DONE;
        end else if (wd_q == WD_W'(BUSY_TIMEOUT - 1)) begin
          error_d    = 1'b1;
          active_d   = 1'b0;
          rr_d       = next_id(gid_q);
          lock_vld_d = 1'b0;
          state_d    = S_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (bus.i_TX_Done) complete = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Completion: release or retain the grant depending on the owner's lock.
    if (complete) begin
      done_d     = onehot(gid_q);
      active_d   = 1'b0;
      rr_d       = next_id(gid_q);
      lock_vld_d = bus.i_Req_Lock[gid_q];
      lock_id_d  = gid_q;
      state_d    = S_IDLE;
    end
  end

  always_ff @(posedge i_System_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= S_IDLE;
      rr_q       <= '0;
      lock_vld_q <= 1'b0;
      lock_id_q  <= '0;
      wd_q       <= '0;
      gid_q      <= '0;
      byte_q     <= '0;
      ack_q      <= '0;
      done_q     <= '0;
      active_q   <= 1'b0;
      error_q    <= 1'b0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      lock_vld_q <= lock_vld_d;
      lock_id_q  <= lock_id_d;
      wd_q       <= wd_d;
      gid_q      <= gid_d;
      byte_q     <= byte_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      active_q   <= active_d;
      error_q    <= error_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign bus.o_Req_Ack  = ack_q;
  assign bus.o_Req_Done = done_q;
  assign bus.o_Grant_ID = gid_q;
  assign bus.o_Active   = active_q;
  assign bus.o_Error    = error_q;
  assign bus.o_TX_Valid = tx_valid_q;
  assign bus.o_TX_Byte  = byte_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table of single transfers plus
// hand sequences for busy-in-idle, dropped valid and mid-transfer reset.
module tb_uart_tx_arbiter;
  localparam int unsigned NR    = 4;
  localparam int unsigned TO    = 16;
  localparam int          FRAME = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus();

  uart_tx_arbiter #(.NUM_REQ(NR), .BUSY_TIMEOUT(TO)) dut (
    .i_System_Clock (clk),
    .i_Rst_L        (rst_n),
    .bus            (bus)
  );

  // UART stub: mode 0 = busy then done after FRAME cycles, 1 = done only, 2 = dead
  logic stub_busy = 1'b0;
  logic stub_done = 1'b0;
  logic hold_busy = 1'b0;
  int   stub_mode = 0;
  int   stub_phase = 0;
  int   stub_cnt = 0;
  assign bus.i_TX_Busy = stub_busy | hold_busy;
  assign bus.i_TX_Done = stub_done;

  initial begin
    forever begin
      @(negedge clk);
      stub_done = 1'b0;
      if (!rst_n) begin
        stub_phase = 0;
        stub_busy  = 1'b0;
      end else begin
        case (stub_phase)
          0: if (bus.o_TX_Valid) begin
               if (stub_mode == 0) begin
                 stub_busy = 1'b1; stub_cnt = FRAME; stub_phase = 1;
               end else if (stub_mode == 1) begin
                 stub_phase = 2;
               end
             end
          1: begin
               stub_cnt--;
               if (stub_cnt == 0) begin
                 stub_busy = 1'b0; stub_done = 1'b1; stub_phase = 0;
               end
             end
          2: begin stub_done = 1'b1; stub_phase = 0; end
          default: stub_phase = 0;
        endcase
      end
    end
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  lock;
    logic [3:0]  post_valid;
    logic [3:0]  post_lock;
    logic [31:0] bytes;
    int          mode;
    int          exp_id;
    logic [7:0]  exp_byte;
    bit          exp_err;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic [3:0] pv,
                              input logic [3:0] pl, input logic [31:0] b, input int m,
                              input int id, input logic [7:0] eb, input bit err);
    vec_t r;
    r.valid = v; r.lock = l; r.post_valid = pv; r.post_lock = pl; r.bytes = b;
    r.mode = m; r.exp_id = id; r.exp_byte = eb; r.exp_err = err;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({bus.o_Req_Ack, bus.o_Req_Done, bus.o_Grant_ID, bus.o_Active,
                bus.o_Error, bus.o_TX_Valid, bus.o_TX_Byte});
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    logic [3:0] exp_oh;
    bit seen;
    int n;
    int extra;
    exp_oh = 4'b0;
    exp_oh[v.exp_id] = 1'b1;
    stub_mode = v.mode;
    bus.i_Req_Valid = v.valid;
    bus.i_Req_Lock  = v.lock;
    bus.i_Req_Byte  = v.bytes;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (bus.o_TX_Valid) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL vec%0d issue_timeout o_TX_Valid=0 required=1", idx);
      return;
    end
    chk($sformatf("vec%0d ack", idx),     64'(bus.o_Req_Ack),  64'(exp_oh));
    chk($sformatf("vec%0d grant", idx),   64'(bus.o_Grant_ID), 64'(v.exp_id));
    chk($sformatf("vec%0d tx_byte", idx), 64'(bus.o_TX_Byte),  64'(v.exp_byte));
    chk($sformatf("vec%0d active", idx),  64'(bus.o_Active),   64'(1));
    bus.i_Req_Valid = v.post_valid;
    bus.i_Req_Lock  = v.post_lock;
    n = 0; seen = 1'b0; extra = 0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (bus.o_Req_Ack != 4'b0 || bus.o_TX_Valid) extra++;
      if (bus.o_Req_Done != 4'b0 || bus.o_Error) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL vec%0d end_timeout no done/error after %0d cycles", idx, n);
      return;
    end
    if (v.exp_err) begin
      chk($sformatf("vec%0d error", idx),       64'(bus.o_Error),    64'(1));
      chk($sformatf("vec%0d err_latency", idx), 64'(n),              64'(17));
      chk($sformatf("vec%0d no_done", idx),     64'(bus.o_Req_Done), 64'(0));
    end else begin
      chk($sformatf("vec%0d done", idx),         64'(bus.o_Req_Done), 64'(exp_oh));
      chk($sformatf("vec%0d no_error", idx),     64'(bus.o_Error),    64'(0));
      chk($sformatf("vec%0d done_latency", idx), 64'(n),              64'((v.mode == 1) ? 2 : 6));
    end
    chk($sformatf("vec%0d inactive", idx),   64'(bus.o_Active), 64'(0));
    chk($sformatf("vec%0d single_ack", idx), 64'(extra),        64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    bit bad;
    bus.i_Req_Valid = '0;
    bus.i_Req_Lock  = '0;
    bus.i_Req_Byte  = '0;

    // single request, RR realignment, all-valid rotation, lock, fast UART, dead UART
    vecs[0]  = mk(4'b0100, 4'b0000, 4'b0000, 4'b0000, 32'hA34FA1A0, 0, 2, 8'h4F, 1'b0);
    vecs[1]  = mk(4'b1000, 4'b0000, 4'b0000, 4'b0000, 32'h3CA2A1A0, 0, 3, 8'h3C, 1'b0);
    vecs[2]  = mk(4'b1111, 4'b0000, 4'b1111, 4'b0000, 32'hA3A2A1A0, 0, 0, 8'hA0, 1'b0);
    vecs[3]  = mk(4'b1111, 4'b0000, 4'b1111, 4'b0000, 32'hA3A2A1A0, 0, 1, 8'hA1, 1'b0);
    vecs[4]  = mk(4'b1111, 4'b0000, 4'b1111, 4'b0000, 32'hA3A2A1A0, 0, 2, 8'hA2, 1'b0);
    vecs[5]  = mk(4'b1111, 4'b0000, 4'b1111, 4'b0000, 32'hA3A2A1A0, 0, 3, 8'hA3, 1'b0);
    vecs[6]  = mk(4'b1111, 4'b0000, 4'b1111, 4'b0000, 32'hA3A2A1A0, 0, 0, 8'hA0, 1'b0);
    vecs[7]  = mk(4'b0011, 4'b0010, 4'b0011, 4'b0010, 32'hA3A21155, 0, 1, 8'h11, 1'b0);
    vecs[8]  = mk(4'b0011, 4'b0010, 4'b0011, 4'b0010, 32'hA3A21255, 0, 1, 8'h12, 1'b0);
    vecs[9]  = mk(4'b0011, 4'b0010, 4'b0011, 4'b0000, 32'hA3A21355, 0, 1, 8'h13, 1'b0);
    vecs[10] = mk(4'b0011, 4'b0000, 4'b0000, 4'b0000, 32'hA3A21355, 0, 0, 8'h55, 1'b0);
    vecs[11] = mk(4'b0100, 4'b0000, 4'b0000, 4'b0000, 32'hA366A1A0, 1, 2, 8'h66, 1'b0);
    vecs[12] = mk(4'b1000, 4'b0000, 4'b0000, 4'b0000, 32'h77A2A1A0, 2, 3, 8'h77, 1'b1);
    vecs[13] = mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 32'hA3A288A0, 0, 1, 8'h88, 1'b0);

    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // UART busy while idle: nothing may issue; a valid dropped meanwhile is never acked
    hold_busy = 1'b1;
    bus.i_Req_Valid = 4'b0001;
    bus.i_Req_Byte  = 32'hA3A2A15A;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.o_TX_Valid || bus.o_Req_Ack != 4'b0) bad = 1'b1;
    end
    chk("busy_idle_no_issue", 64'(bad), 64'(0));
    bus.i_Req_Valid = 4'b0000;
    hold_busy = 1'b0;
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.o_TX_Valid || bus.o_Req_Ack != 4'b0) bad = 1'b1;
    end
    chk("dropped_valid_no_ack", 64'(bad), 64'(0));
    run_vec(14, mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 32'hA3A25BA0, 0, 1, 8'h5B, 1'b0));

    // reset while waiting for done
    stub_mode = 0;
    bus.i_Req_Valid = 4'b0001;
    bus.i_Req_Byte  = 32'hA3A2A121;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (bus.o_TX_Valid) seen = 1'b1;
    end
    chk("t5_issue_seen", 64'(seen), 64'(1));
    bus.i_Req_Valid = 4'b0000;
    repeat (2) @(negedge clk);
    chk("t5_active_before_reset", 64'(bus.o_Active), 64'(1));
    #2 rst_n = 1'b0;
    #1 chk("t5_reset_outputs", all_outs(), 64'(0));
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.o_Req_Done != 4'b0 || bus.o_Error) bad = 1'b1;
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (bus.o_Req_Done != 4'b0 || bus.o_Error || bus.o_Active) bad = 1'b1;
    end
    chk("t5_no_done_after_abort", 64'(bad), 64'(0));
    run_vec(15, mk(4'b1000, 4'b0000, 4'b0000, 4'b0000, 32'h3CA2A1A0, 0, 3, 8'h3C, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
